// File: rtl/iobuf_ctrl_pkg.sv
// Shared types and parameter limits for the I/O buffer turnaround controller.
//   state_e      : controller phase encoding
//   MIN_*        : smallest legal values of the block parameters
//   max_u        : constant helper for counter sizing
//   params_ok    : legality test used at elaboration
package iobuf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TX   = 3'd1,
    ST_TURN = 3'd2,
    ST_RX   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int unsigned MIN_DATA_W   = 1;
  localparam int unsigned MIN_BIT_CYC  = 2;
  localparam int unsigned MIN_TURN_CYC = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit params_ok(input int unsigned data_w,
                                   input int unsigned bit_cyc,
                                   input int unsigned turn_cyc);
    return (data_w >= MIN_DATA_W) && (bit_cyc >= MIN_BIT_CYC) &&
           (turn_cyc >= MIN_TURN_CYC);
  endfunction

endpackage

// File: rtl/iobuf_bit_timer.sv
// Phase timer shared by the TX, TURN and RX phases.
//   clk, reset       : clock, synchronous active-high reset
//   clear_i          : restart the phase (cycle and bit counts to zero)
//   en_i             : advance the counters this cycle
//   turn_i           : current phase is TURN (TURN_CYC-long slot, no sampling)
//   bit_end_c_o      : last cycle of the current bit / turnaround slot
//   sample_c_o       : mid-bit sample point (cycle offset BIT_CYC/2)
//   last_bit_c_o     : bit_end on the final data bit
module iobuf_bit_timer
  import iobuf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BIT_CYC  = 4,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  input  logic turn_i,
  output logic bit_end_c_o,
  output logic sample_c_o,
  output logic last_bit_c_o
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam int unsigned CYC_W = $clog2(max_u(BIT_CYC, TURN_CYC) + 1);

  localparam logic [CYC_W-1:0] BIT_LAST   = CYC_W'(BIT_CYC - 1);
  localparam logic [CYC_W-1:0] TURN_LAST  = CYC_W'(TURN_CYC - 1);
  localparam logic [CYC_W-1:0] SAMPLE_OFF = CYC_W'(BIT_CYC / 2);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_W - 1);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             bit_end;

  // Slot length depends on whether this is a data bit or the turnaround gap
  assign bit_end      = (cyc_q == (turn_i ? TURN_LAST : BIT_LAST));
  assign bit_end_c_o  = bit_end;
  assign sample_c_o   = !turn_i && (cyc_q == SAMPLE_OFF);
  assign last_bit_c_o = bit_end && (bit_q == LAST_BIT);

  // Counter next-state; the bit count saturates so it never wraps in a phase
  always_comb begin
    cyc_d = cyc_q;
    bit_d = bit_q;
    if (clear_i) begin
      cyc_d = '0;
      bit_d = '0;
    end else if (en_i) begin
      if (bit_end) begin
        cyc_d = '0;
        if (bit_q != LAST_BIT) begin
          bit_d = bit_q + BIT_W'(1);
        end
      end else begin
        cyc_d = cyc_q + CYC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      bit_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      bit_q <= bit_d;
    end
  end

endmodule

// File: rtl/iobuf_turnaround_ctrl.sv
// Half-duplex I/O buffer controller: shifts a word out MSB first, optionally
// releases the pad for a turnaround gap and shifts a word back in.
//   clk, reset          : clock, synchronous active-high reset
//   tx_valid/tx_ready   : request handshake (accepted only in IDLE)
//   tx_rd               : a receive phase follows the send phase
//   tx_data             : word to send
//   rx_valid/rx_data    : one-cycle pulse with the received word
//   pad_i, pad_oe       : I/O buffer data input and output enable
//   pad_o               : I/O buffer pad readback (0 when released)
module iobuf_turnaround_ctrl
  import iobuf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BIT_CYC  = 4,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic              tx_rd,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              pad_i,
  output logic              pad_oe,
  input  logic              pad_o
);

  if (!params_ok(DATA_W, BIT_CYC, TURN_CYC)) begin : g_bad_params
    $fatal(1, "iobuf_turnaround_ctrl: illegal DATA_W/BIT_CYC/TURN_CYC");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rd_q, rd_d;
  logic              tx_ready_q, tx_ready_d;
  logic              rx_valid_q, rx_valid_d;
  logic              pad_i_q, pad_i_d;
  logic              pad_oe_q, pad_oe_d;

  logic              timer_clear;
  logic              timer_en;
  logic              bit_end;
  logic              sample;
  logic              last_bit;

  // Every phase change restarts the timer so each phase counts from zero
  assign timer_clear = (state_d != state_q) || (state_q == ST_IDLE);
  assign timer_en    = (state_q == ST_TX) || (state_q == ST_TURN) ||
                       (state_q == ST_RX);

  iobuf_bit_timer #(
    .DATA_W   (DATA_W),
    .BIT_CYC  (BIT_CYC),
    .TURN_CYC (TURN_CYC)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (timer_clear),
    .en_i         (timer_en),
    .turn_i       (state_q == ST_TURN),
    .bit_end_c_o  (bit_end),
    .sample_c_o   (sample),
    .last_bit_c_o (last_bit)
  );

  // Next-state and next-output logic; outputs are derived from the next state
  // so they line up with the phase they belong to.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rd_d       = rd_q;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d    = ST_TX;
          tx_shift_d = tx_data;
          rd_d       = tx_rd;
        end
      end
      ST_TX: begin
        if (last_bit) begin
          state_d = rd_q ? ST_TURN : ST_IDLE;
        end else if (bit_end) begin
          tx_shift_d = tx_shift_q << 1;
        end
      end
      ST_TURN: begin
        if (bit_end) begin
          state_d = ST_RX;
        end
      end
      ST_RX: begin
        if (sample) begin
          rx_shift_d = DATA_W'({rx_shift_q, pad_o});
        end
        // With BIT_CYC=2 the final sample lands on the final bit_end
        if (last_bit) begin
          state_d   = ST_DONE;
          rx_data_d = rx_shift_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tx_ready_d = (state_d == ST_IDLE);
    rx_valid_d = (state_d == ST_DONE);
    pad_oe_d   = (state_d == ST_TX);
    pad_i_d    = (state_d == ST_TX) && tx_shift_d[DATA_W-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rd_q       <= 1'b0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      pad_i_q    <= 1'b0;
      pad_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rd_q       <= rd_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      pad_i_q    <= pad_i_d;
      pad_oe_q   <= pad_oe_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign pad_i    = pad_i_q;
  assign pad_oe   = pad_oe_q;

endmodule

// File: doc/iobuf_turnaround_ctrl.md
IOBUF_TURNAROUND_CTRL -- requirements
Module: iobuf_turnaround_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the bits per transfer.
REQ-002 The block SHALL have parameter BIT_CYC, default 4, giving the clocks per bit.
REQ-003 The block SHALL have parameter TURN_CYC, default 2, giving the bus-released turnaround clocks.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port tx_valid, input, 1 bit: a request is present.
REQ-007 Port tx_rd, input, 1 bit: when set, a receive phase follows the send phase.
REQ-008 Port tx_data, input, DATA_W bits: the word to send.
REQ-009 Port tx_ready, output, 1 bit: the block is idle and can accept a request.
REQ-010 Port rx_valid, output, 1 bit: one-cycle pulse marking rx_data valid.
REQ-011 Port rx_data, output, DATA_W bits: the received word.
REQ-012 Port pad_i, output, 1 bit: drives the I/O buffer data input.
REQ-013 Port pad_oe, output, 1 bit: drives the I/O buffer output enable.
REQ-014 Port pad_o, input, 1 bit: the I/O buffer pad readback; the pad reads 0 when released.

Function
REQ-015 The block SHALL implement the states IDLE, TX, TURN, RX and DONE.
REQ-016 tx_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a clock where tx_valid and tx_ready are both 1; tx_data and tx_rd SHALL be captured at acceptance.
REQ-017 On acceptance the state SHALL go IDLE to TX, and pad_oe SHALL be 1 from the next cycle.
REQ-018 In TX, bits SHALL be sent MSB first on pad_i, each held exactly BIT_CYC cycles, for DATA_W*BIT_CYC cycles in total.
REQ-019 After the last TX bit, the state SHALL go to TURN if the captured tx_rd is 1, otherwise to IDLE.
REQ-020 In TURN, RX, IDLE and DONE, pad_oe SHALL be 0 and pad_i SHALL be 0.
REQ-021 TURN SHALL last exactly TURN_CYC cycles and then go to RX.
REQ-022 In RX, pad_o SHALL be sampled at cycle offset BIT_CYC/2 (floor) of each bit and shifted in MSB first, for DATA_W bits.
REQ-023 After the last RX bit, the state SHALL go to DONE for exactly one cycle, with rx_valid=1 and rx_data equal to the assembled word; DONE SHALL then go to IDLE.
REQ-024 rx_data SHALL hold its value until the next DONE; there is no rx backpressure.
REQ-025 tx_valid asserted while the block is not in IDLE SHALL be ignored, with no queuing.
REQ-026 pad_oe SHALL never be 1 in the same cycle the block samples pad_o.
REQ-027 The bit counter SHALL be ceil(log2(DATA_W+1)) bits wide and the cycle counter ceil(log2(max(BIT_CYC,TURN_CYC)+1)) bits wide, with no wrap inside a phase.
REQ-028 Illegal parameters (BIT_CYC<2, TURN_CYC<1, DATA_W<1) SHALL fail elaboration.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While reset is 1 at a clock edge, the state SHALL become IDLE and tx_ready=1, pad_oe=0, pad_i=0, rx_valid=0 and rx_data=0 on the next cycle.
REQ-031 A reset asserted mid-transfer SHALL abort the transfer, release the pad (pad_oe=0) on the next cycle, and produce no rx_valid.
REQ-032 A tx_valid asserted on a reset cycle SHALL not be accepted.

Structure
REQ-033 Package iobuf_ctrl_pkg SHALL hold the state enum and the parameter-check constants.
REQ-034 Sub-module iobuf_bit_timer SHALL provide the cycle counter, the bit counter, a bit_end strobe and a sample strobe, reused for TX, TURN and RX.
REQ-035 The block SHALL connect to pll_iobuf through pad_i, pad_oe and pad_o only.

Verification (DATA_W=8, BIT_CYC=4, TURN_CYC=2; cycle 0 is the accept edge)
REQ-036 Write 0xA5 with tx_rd=0 -> pad_oe=1 for cycles 1-32; pad_i per 4-cycle bit = 1,0,1,0,0,1,0,1; tx_ready=1 at cycle 33; no rx_valid.
REQ-037 Send 0x3C with tx_rd=1 and the model driving 0x96 on pad_o from cycle 35 -> pad_oe=0 at cycles 33-34; samples at cycles 37, 41, ..., 65; rx_valid=1 only at cycle 67 with rx_data=0x96.
REQ-038 Hold tx_valid=1 continuously -> exactly one accept per IDLE entry, with every accept cycle showing tx_ready=1.
REQ-039 Assert reset at cycle 10 of a TX phase -> pad_oe=0 at cycle 11, tx_ready=1, rx_valid never 1.
REQ-040 Assert reset during RX at cycle 50 -> no rx_valid and rx_data=0; a following read of 0xFF returns 0xFF.
REQ-041 Assertion check -> no cycle has pad_oe=1 together with an RX sample strobe; rx_valid is always exactly one cycle wide.
